icache_assoc: RTL and testbench
===============================

// Module: icache_assoc
// PURPOSE
//  Parametrised instruction cache, successor to the direct-mapped nibble-fill icache.
//  Set-associative (1 or 2 ways) with per-set LRU, 16- or 32-bit fetch width.
//  Owns its own fill FSM, which requests missing lines over the 4-bit memory read path.
//  Lookups hit under an outstanding fill. Sits between the fetch unit and the memory
//  controller.
// PARAMETERS
//  LINE_LENGTH  4   line size in bytes, power of 2, >= RV/8
//  NLINES       4   sets per way, power of 2
//  WAYS         2   associativity, 1 or 2
//  RV           16  fetch data width, 16 or 32
//  PA           22  physical address width
//  (derived) LB = clog2(LINE_LENGTH), SB = clog2(LINE_LENGTH*NLINES)
// PORTS
//  clk          in   1         clock, all state on posedge
//  reset        in   1         synchronous, active-low: 0 = in reset
//  paddr        in   PA-1      fetch address [PA-1:1]
//  fetch        in   1         lookup is live this cycle (LRU update / miss start)
//  flush_all    in   1         invalidate every line
//  hit          out  1         comb: paddr is a valid line in some way
//  rdata        out  RV        comb: fetch data, valid only when hit=1
//  busy         out  1         fill FSM not IDLE
//  fill_req     out  1         line fill request to memory controller
//  fill_addr    out  PA-LB     registered line address [PA-1:LB] of the fill
//  fill_data    in   4         nibble from memory
//  fill_strobe  in   1         fill_data valid this cycle
// BEHAVIOUR
//  Lookup (comb): set = paddr[SB-1:LB], tag = paddr[PA-1:SB].
//   hit = OR over ways of (valid[w][set] && tag[w][set]==tag). At most one way can match.
//   RV=16: halfword select by paddr[LB-1:1]. RV=32: word select by paddr[LB-1:2],
//   paddr[1] ignored.
//  LRU: one bit per set, ignored when WAYS=1.
//   fetch&&hit -> lru[set] <= index of the way NOT hit.
//  FSM states: IDLE, FILL.
//   IDLE: fetch && !hit && flush_all==0 -> FILL.
//    Latch fill_addr = paddr[PA-1:LB] and victim way.
//    Victim: lowest-numbered invalid way, else way lru[set].
//    Clear the victim's valid bit. Clear the nibble counter and the drop flag.
//   FILL: fill_req=1. Each fill_strobe writes fill_data into nibble k of the victim,
//    where k = the counter. Nibble k lands at line bits [(k^1)*4+3:(k^1)*4], so within
//    each byte the high nibble arrives first. Then k <= k+1.
//   On the strobe where k == LINE_LENGTH*2-1:
//    - write the tag;
//    - set valid, unless the drop flag is set;
//    - lru[set] <= other way;
//    - go to IDLE.
//    fill_req is 0 the next cycle.
//  Miss latency: 1 cycle from fetch miss to fill_req=1. hit for the filled address
//   rises the cycle after the last strobe.
//  Hit under fill: lookups to any other line hit normally during FILL. A second miss
//   during FILL is ignored; the fetch unit re-presents it. The victim line never hits
//   mid-fill.
//  flush_all: all valid bits clear next cycle. It has priority over a simultaneous
//   valid set. During FILL it sets the drop flag; the fill runs to completion but the
//   line stays invalid. In IDLE, a simultaneous miss does not start a fill.
//  fill_strobe in IDLE: ignored, no state change.
//  Reset (reset=0): state IDLE; fill_req=0, busy=0, fill_addr=0, counter=0; all valid
//   and LRU bits 0. Data and tag arrays are not reset. Reset mid-fill abandons the fill.
//  Counter width is clog2(LINE_LENGTH*2). It wraps to 0 only through the FILL->IDLE
//   transition.
// TESTING
//  T1 reset=0 for 2 clk, then fetch paddr=0x000 -> hit=0; fill_req=1 next cycle;
//     fill_addr=0x000.
//  T2 strobe nibbles 1,2,3,4,5,6,7,8 -> line=0x78563412; next cycle hit=1, busy=0;
//     RV=16: paddr=0x000 gives 0x3412, paddr=0x002 gives 0x7856.
//  T3 fill 0x000, then 0x010 (same set 0, other tag), touch 0x000, then miss 0x020
//     -> victim is the 0x010 way; 0x000 still hits.
//  T4 while filling 0x004, fetch 0x000 -> hit=1 with correct rdata; fetch 0x008 (miss)
//     -> fill_addr unchanged.
//  T5 flush_all at the 3rd strobe of a fill -> fill completes, busy=0; a refetch of the
//     same address misses. Other lines also miss.
//  T6 reset=0 at the 5th strobe -> fill_req=0, busy=0, hit=0 for all addresses; a fresh
//     miss after reset fills correctly.

Source files
------------

// File: rtl/icache_assoc.sv
// icache_assoc: 1- or 2-way set-associative instruction cache with per-set LRU.
// A nibble-serial fill engine refills missing lines while other lines keep hitting.
module icache_assoc #(
  parameter int LINE_LENGTH = 4,
  parameter int NLINES      = 4,
  parameter int WAYS        = 2,
  parameter int RV          = 16,
  parameter int PA          = 22
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PA-1:1]                    paddr,
  input  logic                             fetch,
  input  logic                             flush_all,
  output logic                             hit,
  output logic [RV-1:0]                    rdata,
  output logic                             busy,
  output logic                             fill_req,
  output logic [PA-1:$clog2(LINE_LENGTH)]  fill_addr,
  input  logic [3:0]                       fill_data,
  input  logic                             fill_strobe
);

  localparam int LB    = $clog2(LINE_LENGTH);
  localparam int SB    = $clog2(LINE_LENGTH * NLINES);
  localparam int SW    = SB - LB;
  localparam int TW    = PA - SB;
  localparam int LBITS = LINE_LENGTH * 8;
  localparam int NNIB  = LINE_LENGTH * 2;
  localparam int CW    = $clog2(NNIB);

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [LBITS-1:0]   data_mem [WAYS][NLINES];
  logic [TW-1:0]      tag_mem  [WAYS][NLINES];
  logic [NLINES-1:0]  valid    [WAYS];
  logic [NLINES-1:0]  lru;

  logic [CW-1:0]      cnt;
  logic               drop;
  logic               fill_way;

  logic [SW-1:0]      set;
  logic [TW-1:0]      tag;
  logic [WAYS-1:0]    way_match;
  logic               hit_way;
  logic               victim;
  logic [LBITS-1:0]   line;
  logic [SW-1:0]      fill_set;
  logic [CW-1:0]      nib_sel;
  logic               last_nib;

  assign set      = paddr[SB-1:LB];
  assign tag      = paddr[PA-1:SB];
  assign fill_set = fill_addr[SB-1:LB];
  assign last_nib = (cnt == CW'(NNIB - 1));
  // The high nibble of each byte arrives first, so flip the nibble index's LSB.
  assign nib_sel  = cnt ^ CW'(1);

  always_comb begin
    way_match = '0;
    hit_way   = 1'b0;
    line      = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_match[w] = valid[w][set] && (tag_mem[w][set] == tag);
      if (way_match[w]) begin
        hit_way = w[0];
        line    = data_mem[w][set];
      end
    end
  end

  assign hit = |way_match;

  generate
    if (LBITS == RV) begin : g_one_word
      assign rdata = line;
    end else begin : g_word_sel
      localparam int WB = (RV == 32) ? 2 : 1;
      assign rdata = line[paddr[LB-1:WB] * RV +: RV];
    end
  endgenerate

  // Prefer an empty way (lowest first) before evicting the LRU way.
  always_comb begin
    victim = (WAYS == 2) ? lru[set] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][set]) victim = w[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && state == FILL && fill_strobe) begin
      data_mem[fill_way][fill_set][{nib_sel, 2'b00} +: 4] <= fill_data;
      if (last_nib) tag_mem[fill_way][fill_set] <= fill_addr[PA-1:SB];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      fill_req  <= 1'b0;
      busy      <= 1'b0;
      fill_addr <= '0;
      cnt       <= '0;
      drop      <= 1'b0;
      fill_way  <= 1'b0;
      lru       <= '0;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
    end else begin
      if (WAYS == 2 && fetch && hit) lru[set] <= ~hit_way;
      case (state)
        IDLE: begin
          if (fetch && !hit && !flush_all) begin
            state                <= FILL;
            fill_req             <= 1'b1;
            busy                 <= 1'b1;
            fill_addr            <= paddr[PA-1:LB];
            fill_way             <= victim;
            valid[victim][set]   <= 1'b0;
            cnt                  <= '0;
            drop                 <= 1'b0;
          end
        end
        FILL: begin
          if (flush_all) drop <= 1'b1;
          if (fill_strobe) begin
            cnt <= cnt + CW'(1);
            if (last_nib) begin
              if (!drop) valid[fill_way][fill_set] <= 1'b1;
              if (WAYS == 2) lru[fill_set] <= ~fill_way;
              cnt      <= '0;
              state    <= IDLE;
              fill_req <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
      endcase
      // A flush overrides any valid bit set in the same cycle.
      if (flush_all) begin
        for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed vector table, hand-written fill corner cases, and a
// randomized run checked against a byte-level model of a 2-way LRU cache.
module tb_icache_assoc;

  localparam int PA = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic [PA-1:1] paddr;
  logic          fetch;
  logic          flush_all;
  logic          hit;
  logic [15:0]   rdata;
  logic          busy;
  logic          fill_req;
  logic [PA-1:2] fill_addr;
  logic [3:0]    fill_data;
  logic          fill_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  icache_assoc #(.LINE_LENGTH(4), .NLINES(4), .WAYS(2), .RV(16), .PA(PA)) dut (
    .clk(clk), .reset(reset), .paddr(paddr), .fetch(fetch), .flush_all(flush_all),
    .hit(hit), .rdata(rdata), .busy(busy), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_strobe(fill_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: per-way bytes/tags/valids plus the way to evict next per set.
  bit           m_valid [2][4];
  int           m_tag   [2][4];
  byte unsigned m_data  [2][4][4];
  int           m_evict [4];

  typedef struct {
    logic [21:0] addr;
    logic        do_fetch;
    logic [31:0] nibs;
    logic        exp_hit;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [21:0] addr, input logic f, input logic fl,
                                input logic st, input logic [3:0] nib);
    paddr       = addr[21:1];
    fetch       = f;
    flush_all   = fl;
    fill_strobe = st;
    fill_data   = nib;
  endtask

  // Entered one cycle after the missing fetch; streams nibbles in arrival order.
  task automatic run_fill(input string name, input logic [31:0] nibs, input logic [19:0] faddr);
    check_output({name, "_req"}, fill_req, 1);
    check_output({name, "_busy"}, busy, 1);
    check_output({name, "_addr"}, fill_addr, faddr);
    for (int k = 0; k < 8; k++) begin
      fill_strobe = 1'b1;
      fill_data   = nibs[31 - 4*k -: 4];
      tick();
    end
    fill_strobe = 1'b0;
    check_output({name, "_done_req"}, fill_req, 0);
    check_output({name, "_done_busy"}, busy, 0);
  endtask

  task automatic probe(input string name, input logic [21:0] addr, input logic exp_hit,
                       input logic [15:0] exp_rd);
    apply_stimulus(addr, 1'b0, 1'b0, 1'b0, 4'h0);
    #1;
    check_output({name, "_hit"}, hit, exp_hit);
    if (exp_hit) check_output({name, "_rdata"}, rdata, exp_rd);
  endtask

  function automatic int model_way(input int a);
    int s = (a >> 2) & 3;
    int t = a >> 4;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[w][s] && m_tag[w][s] == t) return w;
    end
    return -1;
  endfunction

  function automatic int model_half(input int a, input int w);
    int s   = (a >> 2) & 3;
    int off = a & 2;
    return int'(m_data[w][s][off]) | (int'(m_data[w][s][off + 1]) << 8);
  endfunction

  function automatic int rand_addr();
    return ($urandom_range(3, 0) << 4) | ($urandom_range(3, 0) << 2) | ($urandom_range(1, 0) << 1);
  endfunction

  // Compares hit/rdata for the address currently presented, and records LRU use on fetch.
  task automatic model_lookup(input string name, input int a, input bit is_fetch);
    int w;
    #1;
    w = model_way(a);
    check_output({name, "_hit"}, hit, (w >= 0) ? 1 : 0);
    if (w >= 0) begin
      check_output({name, "_rdata"}, rdata, model_half(a, w));
      if (is_fetch) m_evict[(a >> 2) & 3] = 1 - w;
    end
  endtask

  task automatic rand_access(input int a);
    int s, v, other;
    byte unsigned bytes [4];
    s = (a >> 2) & 3;
    apply_stimulus(22'(a), 1'b1, 1'b0, 1'b0, 4'h0);
    model_lookup("rnd", a, 1'b1);
    if (model_way(a) >= 0) begin
      tick();
      fetch = 1'b0;
      return;
    end
    tick();
    fetch = 1'b0;
    v = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : m_evict[s]);
    m_valid[v][s] = 1'b0;
    check_output("rnd_fill_req", fill_req, 1);
    check_output("rnd_fill_addr", fill_addr, a >> 2);
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      fill_strobe = 1'b1;
      fill_data   = (k % 2 == 0) ? 4'(bytes[k/2] >> 4) : 4'(bytes[k/2]);
      if (k < 7 && $urandom_range(1, 0) == 1) begin
        other = rand_addr();
        paddr = 21'(other >> 1);
        fetch = 1'b1;
        model_lookup("rnd_under_fill", other, 1'b1);
      end
      tick();
      fetch = 1'b0;
    end
    fill_strobe = 1'b0;
    check_output("rnd_fill_addr_held", fill_addr, a >> 2);
    check_output("rnd_fill_done_busy", busy, 0);
    m_valid[v][s] = 1'b1;
    m_tag[v][s]   = a >> 4;
    for (int i = 0; i < 4; i++) m_data[v][s][i] = bytes[i];
    m_evict[s] = 1 - v;
  endtask

  initial begin
    vecs[0]  = '{22'h000, 1'b1, 32'h12345678, 1'b0, 16'h0000};
    vecs[1]  = '{22'h000, 1'b0, 32'h0,        1'b1, 16'h3412};
    vecs[2]  = '{22'h002, 1'b0, 32'h0,        1'b1, 16'h7856};
    vecs[3]  = '{22'h010, 1'b1, 32'h9ABCDEF0, 1'b0, 16'h0000};
    vecs[4]  = '{22'h010, 1'b0, 32'h0,        1'b1, 16'hBC9A};
    vecs[5]  = '{22'h012, 1'b0, 32'h0,        1'b1, 16'hF0DE};
    vecs[6]  = '{22'h000, 1'b1, 32'h0,        1'b1, 16'h3412};
    vecs[7]  = '{22'h020, 1'b1, 32'h11223344, 1'b0, 16'h0000};
    vecs[8]  = '{22'h020, 1'b0, 32'h0,        1'b1, 16'h2211};
    vecs[9]  = '{22'h022, 1'b0, 32'h0,        1'b1, 16'h4433};
    vecs[10] = '{22'h000, 1'b0, 32'h0,        1'b1, 16'h3412};
    vecs[11] = '{22'h010, 1'b0, 32'h0,        1'b0, 16'h0000};

    reset = 1'b0;
    apply_stimulus(22'h000, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    reset = 1'b1;
    check_output("reset_fill_req", fill_req, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_fill_addr", fill_addr, 0);
    probe("reset_lookup", 22'h000, 1'b0, 16'h0);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].do_fetch, 1'b0, 1'b0, 4'h0);
      #1;
      check_output($sformatf("vec%0d_hit", i), hit, vecs[i].exp_hit);
      if (vecs[i].exp_hit) check_output($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      tick();
      fetch = 1'b0;
      if (vecs[i].do_fetch && !vecs[i].exp_hit)
        run_fill($sformatf("vec%0d_fill", i), vecs[i].nibs, vecs[i].addr[21:2]);
    end

    // Hit under fill, ignored second miss, victim invisible mid-fill.
    apply_stimulus(22'h004, 1'b1, 1'b0, 1'b0, 4'h0);
    #1;
    check_output("t4_miss", hit, 0);
    tick();
    fetch = 1'b0;
    check_output("t4_req", fill_req, 1);
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(22'h004, 1'b0, 1'b0, 1'b1, 4'(32'hCAFEF00D >> (28 - 4*k)));
      if (k == 2) begin
        apply_stimulus(22'h000, 1'b1, 1'b0, 1'b1, fill_data);
        #1;
        check_output("t4_under_hit", hit, 1);
        check_output("t4_under_rdata", rdata, 16'h3412);
      end
      if (k == 3) begin
        apply_stimulus(22'h008, 1'b1, 1'b0, 1'b1, fill_data);
        #1;
        check_output("t4_second_miss", hit, 0);
      end
      if (k == 4) check_output("t4_addr_kept", fill_addr, 20'h1);
      if (k == 5) begin
        #1;
        check_output("t4_victim_hidden", hit, 0);
      end
      tick();
    end
    fill_strobe = 1'b0;
    check_output("t4_done_busy", busy, 0);
    probe("t4_lo", 22'h004, 1'b1, 16'hFECA);
    probe("t4_hi", 22'h006, 1'b1, 16'h0DF0);

    // Flush on the third strobe drops the line being filled.
    apply_stimulus(22'h008, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    fetch = 1'b0;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(22'h008, 1'b0, (k == 2), 1'b1, 4'(k + 1));
      if (k == 3) check_output("t5_still_busy", busy, 1);
      tick();
    end
    apply_stimulus(22'h008, 1'b0, 1'b0, 1'b0, 4'h0);
    check_output("t5_done_busy", busy, 0);
    probe("t5_dropped", 22'h008, 1'b0, 16'h0);
    probe("t5_other0", 22'h000, 1'b0, 16'h0);
    probe("t5_other1", 22'h004, 1'b0, 16'h0);
    apply_stimulus(22'h008, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    fetch = 1'b0;
    run_fill("t5_refill", 32'h11223344, 20'h2);
    probe("t5_refill_hit", 22'h008, 1'b1, 16'h2211);

    // Reset on the fifth strobe abandons the fill and clears every line.
    apply_stimulus(22'h00C, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    fetch = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(22'h00C, 1'b0, 1'b0, 1'b1, 4'hA);
      if (k == 4) reset = 1'b0;
      tick();
    end
    reset = 1'b1;
    fill_strobe = 1'b0;
    check_output("t6_req", fill_req, 0);
    check_output("t6_busy", busy, 0);
    check_output("t6_addr", fill_addr, 0);
    probe("t6_line8", 22'h008, 1'b0, 16'h0);
    probe("t6_lineC", 22'h00C, 1'b0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(22'h00C, 1'b0, 1'b0, 1'b1, 4'hF);
      tick();
    end
    apply_stimulus(22'h00C, 1'b1, 1'b1, 1'b0, 4'h0);
    tick();
    check_output("idle_flush_miss_busy", busy, 0);
    apply_stimulus(22'h00C, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    fetch = 1'b0;
    run_fill("t6_fresh", 32'h13579BDF, 20'h3);
    probe("t6_fresh_lo", 22'h00C, 1'b1, 16'h5713);
    probe("t6_fresh_hi", 22'h00E, 1'b1, 16'hDF9B);

    // Randomized traffic against the model.
    reset = 1'b0;
    apply_stimulus(22'h000, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    reset = 1'b1;
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 4; s++) m_valid[w][s] = 1'b0;
    for (int s = 0; s < 4; s++) m_evict[s] = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(15, 0) == 0) begin
        int a = rand_addr();
        apply_stimulus(22'(a), 1'b1, 1'b1, 1'b0, 4'h0);
        model_lookup("rnd_flush", a, 1'b1);
        tick();
        apply_stimulus(22'(a), 1'b0, 1'b0, 1'b0, 4'h0);
        check_output("rnd_flush_idle", busy, 0);
        for (int w = 0; w < 2; w++)
          for (int s = 0; s < 4; s++) m_valid[w][s] = 1'b0;
      end else begin
        rand_access(rand_addr());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
